noc_flit_receiver: RTL and testbench

Local-port packet receiver for the NoC. It accepts the header / data / tail flit stream that a router ejects toward a node and strips the header and tail flits. Payload flits are forwarded through a 2-entry output FIFO to the local consumer. For each packet it reports completion, source ID and length, and it flags protocol violations. It pairs with the test-node packet sender and is the receive half of every endpoint.

---
 rtl/noc_flit_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_noc_flit_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_receiver.sv
// Local-port NoC packet receiver: strips header/tail flits and forwards payload through a 2-entry FIFO.
// Build option: define NOC_RX_DEST_CHECK_EN to reject headers not addressed to (X_ID, Y_ID).
module noc_flit_receiver #(
  parameter int         X_ID      = 0,
  parameter int         Y_ID      = 0,
  parameter int         DATA_W    = 64,
  parameter int         ID_W      = 4,
  parameter int         LEN_W     = 8,
  parameter logic [7:0] HEAD_MARK = 8'hF0,
  parameter logic [7:0] TAIL_MARK = 8'h0F
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_is_header,
  input  logic              in_is_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              pkt_done,
  output logic [ID_W-1:0]   pkt_src_x,
  output logic [ID_W-1:0]   pkt_src_y,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [15:0]       pkt_count,
  output logic              err_flag,
  output logic [2:0]        err_code,
  input  logic              err_clr
);

  // state   | meaning
  // IDLE    | waiting for a header
  // DATA    | receiving payload of the current packet
  // DISCARD | dropping flits up to and including the next tail
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DISCARD} state_e;

  localparam logic [2:0] ERR_ORPHAN = 3'd1;
  localparam logic [2:0] ERR_HEAD   = 3'd2;
  localparam logic [2:0] ERR_LEN    = 3'd3;
  localparam logic [2:0] ERR_ABORT  = 3'd4;
  localparam logic [2:0] ERR_DEST   = 3'd5;
  localparam logic [2:0] ERR_TAIL   = 3'd6;

  localparam int MK_LO = DATA_W - 8;
  localparam int SX_LO = MK_LO - ID_W;
  localparam int SY_LO = SX_LO - ID_W;
  localparam int DX_LO = SY_LO - ID_W;
  localparam int DY_LO = DX_LO - ID_W;
  localparam int LN_LO = DY_LO - LEN_W;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [ID_W-1:0]    src_x_q, src_x_d, src_y_q, src_y_d;
  logic               pkt_done_q;
  logic [ID_W-1:0]    pkt_src_x_q, pkt_src_y_q;
  logic [LEN_W-1:0]   pkt_len_q;
  logic [15:0]        pkt_count_q;
  logic               err_flag_q, err_flag_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [DATA_W-1:0]  fifo_data_q [2];
  logic [1:0]         fifo_last_q;
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         fifo_cnt_q;

  logic [7:0] mark;
  logic       dest_ok, fifo_full, acc, pop, push, push_last, done, err_hit;
  logic [2:0] err_new;
  logic       unused_bits;

  assign mark      = in_flit[DATA_W-1:MK_LO];
  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign in_ready  = (state_q == S_DATA) ? !fifo_full : 1'b1;
  assign acc       = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

`ifdef NOC_RX_DEST_CHECK_EN
  assign dest_ok = (in_flit[DX_LO +: ID_W] == X_ID[ID_W-1:0]) &&
                   (in_flit[DY_LO +: ID_W] == Y_ID[ID_W-1:0]);
`else
  assign dest_ok = 1'b1;
`endif
  assign unused_bits = ^{in_flit, X_ID[ID_W-1:0], Y_ID[ID_W-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    push      = 1'b0;
    push_last = 1'b0;
    done      = 1'b0;
    err_hit   = 1'b0;
    err_new   = 3'd0;
    if (acc) begin
      // A header in DATA aborts the current packet and is then decoded like one in IDLE.
      if (in_is_header && state_q != S_DISCARD) begin
        if (mark != HEAD_MARK) begin
          err_hit = 1'b1;
          err_new = ERR_HEAD;
          state_d = S_DISCARD;
        end else if (!dest_ok) begin
          err_hit = 1'b1;
          err_new = ERR_DEST;
          state_d = S_DISCARD;
        end else begin
          src_x_d = in_flit[SX_LO +: ID_W];
          src_y_d = in_flit[SY_LO +: ID_W];
          len_d   = in_flit[LN_LO +: LEN_W];
          cnt_d   = '0;
          state_d = S_DATA;
        end
        if (state_q == S_DATA) begin
          err_hit = 1'b1;
          err_new = ERR_ABORT;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            err_hit = 1'b1;
            err_new = ERR_ORPHAN;
          end
          S_DATA: begin
            if (in_is_tail) begin
              state_d = S_IDLE;
              if (mark != TAIL_MARK) begin
                err_hit = 1'b1;
                err_new = ERR_TAIL;
              end else if (cnt_q != len_q) begin
                err_hit = 1'b1;
                err_new = ERR_LEN;
              end else begin
                done = 1'b1;
              end
            end else if (cnt_q < len_q) begin
              push      = 1'b1;
              push_last = (cnt_q + LEN_W'(1) == len_q);
              cnt_d     = cnt_q + LEN_W'(1);
            end else begin
              err_hit = 1'b1;
              err_new = ERR_LEN;
              state_d = S_DISCARD;
            end
          end
          S_DISCARD: if (in_is_tail) state_d = S_IDLE;
          default:   state_d = S_IDLE;
        endcase
      end
    end
  end

  // A new error beats a simultaneous clear; otherwise the first error is held.
  always_comb begin
    err_flag_d = err_flag_q;
    err_code_d = err_code_q;
    if (err_hit) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) err_code_d = err_new;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_code_d = 3'd0;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      src_x_q        <= '0;
      src_y_q        <= '0;
      pkt_done_q     <= 1'b0;
      pkt_src_x_q    <= '0;
      pkt_src_y_q    <= '0;
      pkt_len_q      <= '0;
      pkt_count_q    <= '0;
      err_flag_q     <= 1'b0;
      err_code_q     <= 3'd0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
      pkt_done_q <= done;
      if (done) begin
        pkt_src_x_q <= src_x_q;
        pkt_src_y_q <= src_y_q;
        pkt_len_q   <= len_q;
        if (pkt_count_q != 16'hFFFF) pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= in_flit;
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign pkt_done  = pkt_done_q;
  assign pkt_src_x = pkt_src_x_q;
  assign pkt_src_y = pkt_src_y_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_count = pkt_count_q;
  assign err_flag  = err_flag_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Scoreboard bench for noc_flit_receiver: packet-level reference model, directed cases then random traffic.
module tb_noc_flit_receiver;
  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        in_valid, in_ready, in_is_header, in_is_tail;
  logic [63:0] in_flit;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        pkt_done;
  logic [3:0]  pkt_src_x, pkt_src_y;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_count;
  logic        err_flag, err_clr;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  always #5 noc_clk = ~noc_clk;

  noc_flit_receiver #(.X_ID(2), .Y_ID(3)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pkt_done(pkt_done), .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y),
    .pkt_len(pkt_len), .pkt_count(pkt_count),
    .err_flag(err_flag), .err_code(err_code), .err_clr(err_clr)
  );

  // Reference model: packet-level view of the accepted flit stream.
  logic [64:0] exp_q[$];
  int m_state, m_cnt, m_len, m_sx, m_sy, m_count, m_ec;
  bit m_ef, done_pend;
  int d_sx, d_sy, d_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_state = 0; m_cnt = 0; m_len = 0; m_sx = 0; m_sy = 0;
    m_count = 0; m_ec = 0; m_ef = 0; done_pend = 0;
  endfunction

  function automatic bit dest_mismatch(input logic [63:0] f);
`ifdef NOC_RX_DEST_CHECK_EN
    return (f[47:44] != 4'd2) || (f[43:40] != 4'd3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step(input logic [63:0] f, input bit h, input bit t,
                                     input bit acc, input bit clr);
    int e = 0;
    logic lst;
    if (acc) begin
      if (h && m_state != 2) begin
        if (m_state == 1) e = 4;
        if (f[63:56] != 8'hF0) begin
          if (e == 0) e = 2;
          m_state = 2;
        end else if (dest_mismatch(f)) begin
          if (e == 0) e = 5;
          m_state = 2;
        end else begin
          m_sx = int'(f[55:52]); m_sy = int'(f[51:48]); m_len = int'(f[39:32]);
          m_cnt = 0; m_state = 1;
        end
      end else if (m_state == 0) begin
        e = 1;
      end else if (m_state == 1) begin
        if (t) begin
          m_state = 0;
          if (f[63:56] != 8'h0F) e = 6;
          else if (m_cnt != m_len) e = 3;
          else begin
            done_pend = 1; d_sx = m_sx; d_sy = m_sy; d_len = m_len;
            if (m_count < 65535) m_count++;
          end
        end else if (m_cnt < m_len) begin
          lst = (m_cnt + 1 == m_len);
          exp_q.push_back({lst, f});
          m_cnt++;
        end else begin
          e = 3; m_state = 2;
        end
      end else if (t) begin
        m_state = 0;
      end
    end
    if (e != 0) begin
      if (!m_ef || clr) m_ec = e;
      m_ef = 1;
    end else if (clr) begin
      m_ef = 0; m_ec = 0;
    end
  endfunction

  always @(posedge noc_clk) begin
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares DUT outputs against the model, then feeds the model this cycle's inputs.
  always @(negedge noc_clk) begin
    if (!noc_rst_n) begin
      model_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_err_flag", err_flag, 0);
    end else begin
      check("in_ready", in_ready, !(m_state == 1 && exp_q.size() == 2));
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0][63:0]);
        check("out_last", out_last, exp_q[0][64]);
        if (out_ready) void'(exp_q.pop_front());
      end
      check("pkt_done", pkt_done, done_pend);
      if (pkt_done && done_pend) begin
        check("pkt_src_x", pkt_src_x, d_sx);
        check("pkt_src_y", pkt_src_y, d_sy);
        check("pkt_len", pkt_len, d_len);
      end
      check("pkt_count", pkt_count, m_count);
      check("err_flag", err_flag, m_ef);
      check("err_code", err_code, m_ec);
      done_pend = 0;
      model_step(in_flit, in_is_header, in_is_tail, in_valid && in_ready, err_clr);
    end
  end

  function automatic logic [63:0] make_hdr(input logic [7:0] mk, input int sx, input int sy,
                                           input int dx, input int dy, input int len);
    return {mk, 4'(sx), 4'(sy), 4'(dx), 4'(dy), 8'(len), 32'($urandom)};
  endfunction

  task automatic send_flit(input logic [63:0] f, input logic h, input logic t);
    int n = 0;
    in_flit = f; in_is_header = h; in_is_tail = t; in_valid = 1'b1;
    do begin
      @(negedge noc_clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: actual in_ready 0 required 1 within 500 cycles");
    end
    @(posedge noc_clk); #1;
    in_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge noc_clk); #1;
    end
  endtask

  task automatic send_pkt(input int sx, input int sy, input int dx, input int dy, input int len,
                          input int nd, input logic [7:0] mh, input logic [7:0] mt, input bit tl);
    send_flit(make_hdr(mh, sx, sy, dx, dy, len), 1'b1, 1'b0);
    for (int i = 0; i < nd; i++) send_flit({$urandom, $urandom}, 1'b0, 1'b0);
    if (tl) send_flit(make_hdr(mt, sx, sy, dx, dy, len), 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge noc_clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int len, nd, dx, k;
    logic [7:0] mh, mt;
    bit tl;
    in_valid = 0; in_flit = '0; in_is_header = 0; in_is_tail = 0; err_clr = 0;
    idle(3);
    noc_rst_n = 1'b1;
    idle(2);
    send_pkt(1, 1, 2, 3, 3, 3, 8'hF0, 8'h0F, 1);
    idle(5);
    fork
      begin ready_mode = 2; repeat (10) @(posedge noc_clk); ready_mode = 0; end
    join_none
    send_pkt(1, 1, 2, 3, 3, 3, 8'hF0, 8'h0F, 1);
    idle(15);
    send_pkt(2, 0, 2, 3, 2, 1, 8'hF0, 8'h0F, 1);
    send_pkt(3, 4, 2, 3, 1, 1, 8'hF0, 8'h0F, 1);
    send_pkt(9, 9, 2, 3, 0, 0, 8'hF0, 8'h0F, 1);
    send_flit({$urandom, $urandom}, 1'b0, 1'b0);
    pulse_clr();
    send_pkt(5, 5, 2, 3, 2, 2, 8'h00, 8'h0F, 1);
    pulse_clr();
    send_flit(make_hdr(8'hF0, 6, 6, 2, 3, 4), 1'b1, 1'b0);
    send_flit({$urandom, $urandom}, 1'b0, 1'b0);
    send_pkt(7, 7, 2, 3, 2, 2, 8'hF0, 8'h0F, 1);
    pulse_clr();
    send_pkt(1, 2, 1, 3, 2, 2, 8'hF0, 8'h0F, 1);
    send_pkt(1, 2, 2, 3, 2, 2, 8'hF0, 8'h0F, 1);
    pulse_clr();
    ready_mode = 1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(0, 5); nd = len; mh = 8'hF0; mt = 8'h0F; tl = 1; dx = 2;
      k = $urandom_range(0, 11);
      case (k)
        0: nd = len + 1;
        1: nd = (len > 0) ? len - 1 : 0;
        2: mh = 8'($urandom);
        3: mt = 8'h00;
        4: tl = 0;
        5: dx = $urandom_range(0, 15);
        6: send_flit({$urandom, $urandom}, 1'b0, $urandom_range(0, 1) == 1);
        default: ;
      endcase
      send_pkt($urandom_range(0, 15), $urandom_range(0, 15), dx, 3, len, nd, mh, mt, tl);
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end
    ready_mode = 0;
    idle(5);
    send_flit(make_hdr(8'hF0, 4, 4, 2, 3, 4), 1'b1, 1'b0);
    send_flit({$urandom, $urandom}, 1'b0, 1'b0);
    send_flit({$urandom, $urandom}, 1'b0, 1'b0);
    noc_rst_n = 1'b0;
    idle(2);
    noc_rst_n = 1'b1;
    idle(2);
    send_pkt(8, 1, 2, 3, 2, 2, 8'hF0, 8'h0F, 1);
    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
